// File: rtl/ime_partition_decision_pipe_if.sv
// IME partition decision pipe bus bundle.
// Upstream cost set, mode controls and downstream result.
interface ime_partition_decision_pipe_if #(
  parameter int COST_WIDTH  = 26,
  parameter int BIAS_WIDTH  = 8,
  parameter int PIC_X_WIDTH = 8,
  parameter int PIC_Y_WIDTH = 8,
  parameter int ACC_WIDTH   = COST_WIDTH + 8
);
  logic                   in_val_i;
  logic                   in_rdy_o;
  logic                   in_last_i;
  logic [COST_WIDTH-1:0]  cst_1nx1n_0_i;
  logic [COST_WIDTH-1:0]  cst_1nx1n_1_i;
  logic [COST_WIDTH-1:0]  cst_1nx1n_2_i;
  logic [COST_WIDTH-1:0]  cst_1nx1n_3_i;
  logic [COST_WIDTH-1:0]  cst_1nx2n_0_i;
  logic [COST_WIDTH-1:0]  cst_1nx2n_1_i;
  logic [COST_WIDTH-1:0]  cst_2nx1n_0_i;
  logic [COST_WIDTH-1:0]  cst_2nx1n_1_i;
  logic [COST_WIDTH-1:0]  cst_2nx2n_i;
  logic [5:0]             part_x_i;
  logic [5:0]             part_y_i;
  logic [PIC_X_WIDTH-1:0] ctu_x_all_i;
  logic [PIC_X_WIDTH-1:0] ctu_x_cur_i;
  logic [PIC_Y_WIDTH-1:0] ctu_y_all_i;
  logic [PIC_Y_WIDTH-1:0] ctu_y_cur_i;
  logic [5:0]             ctu_x_res_i;
  logic [5:0]             ctu_y_res_i;
  logic [3:0]             mode_en_i;
  logic [BIAS_WIDTH-1:0]  bias_2nx2n_i;
  logic [BIAS_WIDTH-1:0]  bias_2nx1n_i;
  logic [BIAS_WIDTH-1:0]  bias_1nx2n_i;
  logic [BIAS_WIDTH-1:0]  bias_1nx1n_i;
  logic                   out_val_o;
  logic                   out_rdy_i;
  logic [1:0]             out_part_o;
  logic [COST_WIDTH-1:0]  out_cst_o;
  logic                   out_last_o;
  logic [ACC_WIDTH-1:0]   out_ctu_cst_o;

  modport master (
    output in_val_i, in_last_i,
    output cst_1nx1n_0_i, cst_1nx1n_1_i,
    output cst_1nx1n_2_i, cst_1nx1n_3_i,
    output cst_1nx2n_0_i, cst_1nx2n_1_i,
    output cst_2nx1n_0_i, cst_2nx1n_1_i,
    output cst_2nx2n_i,
    output part_x_i, part_y_i,
    output ctu_x_all_i, ctu_x_cur_i,
    output ctu_y_all_i, ctu_y_cur_i,
    output ctu_x_res_i, ctu_y_res_i,
    output mode_en_i,
    output bias_2nx2n_i, bias_2nx1n_i,
    output bias_1nx2n_i, bias_1nx1n_i,
    output out_rdy_i,
    input  in_rdy_o,
    input  out_val_o, out_part_o, out_cst_o,
    input  out_last_o, out_ctu_cst_o
  );

  modport slave (
    input  in_val_i, in_last_i,
    input  cst_1nx1n_0_i, cst_1nx1n_1_i,
    input  cst_1nx1n_2_i, cst_1nx1n_3_i,
    input  cst_1nx2n_0_i, cst_1nx2n_1_i,
    input  cst_2nx1n_0_i, cst_2nx1n_1_i,
    input  cst_2nx2n_i,
    input  part_x_i, part_y_i,
    input  ctu_x_all_i, ctu_x_cur_i,
    input  ctu_y_all_i, ctu_y_cur_i,
    input  ctu_x_res_i, ctu_y_res_i,
    input  mode_en_i,
    input  bias_2nx2n_i, bias_2nx1n_i,
    input  bias_1nx2n_i, bias_1nx1n_i,
    input  out_rdy_i,
    output in_rdy_o,
    output out_val_o, out_part_o, out_cst_o,
    output out_last_o, out_ctu_cst_o
  );
endinterface

// File: rtl/ime_partition_decision_pipe.sv
// Two-stage IME partition decision with bias, mode mask,
// backpressure and saturating per-CTU best-cost accumulator.
module ime_partition_decision_pipe #(
  parameter int COST_WIDTH  = 26,
  parameter int BIAS_WIDTH  = 8,
  parameter int PIC_X_WIDTH = 8,
  parameter int PIC_Y_WIDTH = 8,
  parameter int LCU_SIZE    = 64,
  parameter int ACC_WIDTH   = COST_WIDTH + 8
) (
  input logic clk,
  input logic rstn,
  ime_partition_decision_pipe_if.slave bus
);
  localparam int SW  = COST_WIDTH + 2;
  localparam int BW  = COST_WIDTH + 3;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic [6:0] LCU7 = 7'(LCU_SIZE);

  // array index equals the partition code
  localparam logic [1:0] P2N2N = 2'd0;
  localparam logic [1:0] P2N1N = 2'd1;
  localparam logic [1:0] P1N2N = 2'd2;
  localparam logic [1:0] P1N1N = 2'd3;

  logic          en;
  logic [SW-1:0] sum_d [4];
  logic [BW-1:0] bc_d  [4];
  logic          bnd_x;
  logic          bnd_y;

  logic          s1_val_q;
  logic [SW-1:0] s1_sum_q [4];
  logic [BW-1:0] s1_bc_q  [4];
  logic          s1_bnd_q;
  logic [3:0]    s1_en_q;
  logic          s1_last_q;

  logic [BW-1:0]         bc_m [4];
  logic [1:0]            a_sel;
  logic [1:0]            b_sel;
  logic [1:0]            part_d;
  logic [SW-1:0]         sum_w;
  logic [COST_WIDTH-1:0] cst_d;
  logic [ACC_WIDTH-1:0]  acc_base;
  logic [AW1-1:0]        acc_sum;
  logic [ACC_WIDTH-1:0]  acc_d;

  logic                  out_val_q;
  logic [1:0]            out_part_q;
  logic [COST_WIDTH-1:0] out_cst_q;
  logic                  out_last_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  prev_last_q;

  assign en           = !out_val_q || bus.out_rdy_i;
  assign bus.in_rdy_o = en;

  // mode sums, biased sums and edge-CTU boundary test
  always_comb begin
    sum_d[P2N2N] = SW'(bus.cst_2nx2n_i);
    sum_d[P2N1N] = SW'(bus.cst_2nx1n_0_i)
                 + SW'(bus.cst_2nx1n_1_i);
    sum_d[P1N2N] = SW'(bus.cst_1nx2n_0_i)
                 + SW'(bus.cst_1nx2n_1_i);
    sum_d[P1N1N] = SW'(bus.cst_1nx1n_0_i)
                 + SW'(bus.cst_1nx1n_1_i)
                 + SW'(bus.cst_1nx1n_2_i)
                 + SW'(bus.cst_1nx1n_3_i);
    bc_d[P2N2N] = BW'(sum_d[P2N2N])
                + BW'(bus.bias_2nx2n_i);
    bc_d[P2N1N] = BW'(sum_d[P2N1N])
                + BW'(bus.bias_2nx1n_i);
    bc_d[P1N2N] = BW'(sum_d[P1N2N])
                + BW'(bus.bias_1nx2n_i);
    bc_d[P1N1N] = BW'(sum_d[P1N1N])
                + BW'(bus.bias_1nx1n_i);
    // residual 0 gives LCU_SIZE, which no 6-bit offset exceeds
    bnd_x = ({1'b0, bus.part_x_i}
             > (LCU7 - {1'b0, bus.ctu_x_res_i}))
         && (bus.ctu_x_cur_i == bus.ctu_x_all_i);
    bnd_y = ({1'b0, bus.part_y_i}
             > (LCU7 - {1'b0, bus.ctu_y_res_i}))
         && (bus.ctu_y_cur_i == bus.ctu_y_all_i);
  end

  // S1: capture sums and controls when the pipe advances
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_val_q <= 1'b0;
    end else if (en) begin
      s1_val_q  <= bus.in_val_i;
      s1_bnd_q  <= bnd_x || bnd_y;
      s1_en_q   <= bus.mode_en_i;
      s1_last_q <= bus.in_last_i;
      for (int i = 0; i < 4; i++) begin
        s1_sum_q[i] <= sum_d[i];
        s1_bc_q[i]  <= bc_d[i];
      end
    end
  end

  // decision tree, cost saturation and accumulator next value
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bc_m[i] = s1_en_q[i] ? s1_bc_q[i] : '1;
    end
    a_sel = (bc_m[P1N1N] < bc_m[P2N1N]) ? P1N1N : P2N1N;
    b_sel = (bc_m[P1N2N] < bc_m[P2N2N]) ? P1N2N : P2N2N;
    if (s1_bnd_q) begin
      part_d = P1N1N;
    end else if (s1_en_q == 4'd0) begin
      part_d = P2N2N;
    end else begin
      part_d = (bc_m[a_sel] < bc_m[b_sel]) ? a_sel : b_sel;
    end
    sum_w = s1_sum_q[part_d];
    cst_d = (|sum_w[SW-1:COST_WIDTH]) ? '1
          : sum_w[COST_WIDTH-1:0];
    acc_base = prev_last_q ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + AW1'(cst_d);
    acc_d    = acc_sum[ACC_WIDTH] ? '1
             : acc_sum[ACC_WIDTH-1:0];
  end

  // S2: output registers and per-CTU accumulator
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_val_q   <= 1'b0;
      out_part_q  <= 2'd0;
      out_cst_q   <= '0;
      out_last_q  <= 1'b0;
      acc_q       <= '0;
      prev_last_q <= 1'b1;
    end else if (en) begin
      out_val_q <= s1_val_q;
      if (s1_val_q) begin
        out_part_q  <= part_d;
        out_cst_q   <= cst_d;
        out_last_q  <= s1_last_q;
        acc_q       <= acc_d;
        prev_last_q <= s1_last_q;
      end
    end
  end

  assign bus.out_val_o     = out_val_q;
  assign bus.out_part_o    = out_part_q;
  assign bus.out_cst_o     = out_cst_q;
  assign bus.out_last_o    = out_last_q;
  assign bus.out_ctu_cst_o = acc_q;
endmodule

// File: tb/tb_ime_partition_decision_pipe.sv
// Directed bench for ime_partition_decision_pipe with a
// reference model feeding an in-order scoreboard.
module tb_ime_partition_decision_pipe;
  localparam int CW = 26;
  localparam int AW = CW + 8;
  localparam longint CMAX = (64'd1 << CW) - 1;
  localparam longint AMAX = (64'd1 << AW) - 1;
  localparam longint BIG  = 64'h7fff_ffff_ffff_ffff;

  typedef struct {
    longint c0, c1, c2, c3, h0, h1, v0, v1, w;
    int px, py, xall, xcur, yall, ycur, xres, yres;
    int men, b22, b21, b12, b11, last;
  } cu_t;

  typedef struct {
    int part;
    longint cst;
    int last;
    longint ctu;
  } exp_t;

  logic clk;
  logic rstn;
  int vec = 0;
  int mis = 0;
  exp_t q[$];
  longint acc_m;
  int pl_m;
  bit acc_ok;

  ime_partition_decision_pipe_if #(
    .COST_WIDTH(CW), .BIAS_WIDTH(8),
    .PIC_X_WIDTH(8), .PIC_Y_WIDTH(8), .ACC_WIDTH(AW)
  ) bus ();

  ime_partition_decision_pipe #(
    .COST_WIDTH(CW), .BIAS_WIDTH(8),
    .PIC_X_WIDTH(8), .PIC_Y_WIDTH(8),
    .LCU_SIZE(64), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic cu_t mk(longint qc, longint hc,
                             longint vc, longint wc);
    cu_t c;
    c.c0 = qc; c.c1 = qc; c.c2 = qc; c.c3 = qc;
    c.h0 = hc; c.h1 = hc; c.v0 = vc; c.v1 = vc; c.w = wc;
    c.px = 0; c.py = 0; c.xall = 0; c.xcur = 0;
    c.yall = 0; c.ycur = 0; c.xres = 0; c.yres = 0;
    c.men = 15; c.b22 = 0; c.b21 = 0; c.b12 = 0; c.b11 = 0;
    c.last = 0;
    return c;
  endfunction

  task automatic drive(cu_t c);
    bus.cst_1nx1n_0_i = CW'(c.c0);
    bus.cst_1nx1n_1_i = CW'(c.c1);
    bus.cst_1nx1n_2_i = CW'(c.c2);
    bus.cst_1nx1n_3_i = CW'(c.c3);
    bus.cst_2nx1n_0_i = CW'(c.h0);
    bus.cst_2nx1n_1_i = CW'(c.h1);
    bus.cst_1nx2n_0_i = CW'(c.v0);
    bus.cst_1nx2n_1_i = CW'(c.v1);
    bus.cst_2nx2n_i   = CW'(c.w);
    bus.part_x_i      = 6'(c.px);
    bus.part_y_i      = 6'(c.py);
    bus.ctu_x_all_i   = 8'(c.xall);
    bus.ctu_x_cur_i   = 8'(c.xcur);
    bus.ctu_y_all_i   = 8'(c.yall);
    bus.ctu_y_cur_i   = 8'(c.ycur);
    bus.ctu_x_res_i   = 6'(c.xres);
    bus.ctu_y_res_i   = 6'(c.yres);
    bus.mode_en_i     = 4'(c.men);
    bus.bias_2nx2n_i  = 8'(c.b22);
    bus.bias_2nx1n_i  = 8'(c.b21);
    bus.bias_1nx2n_i  = 8'(c.b12);
    bus.bias_1nx1n_i  = 8'(c.b11);
    bus.in_last_i     = c.last[0];
  endtask

  // reference: pick partition, cost and running CTU total
  task automatic model(cu_t c);
    longint s[4];
    longint bs[4];
    longint bias[4];
    exp_t e;
    int a, b;
    bit bnd;
    s[0] = c.w;
    s[1] = c.h0 + c.h1;
    s[2] = c.v0 + c.v1;
    s[3] = c.c0 + c.c1 + c.c2 + c.c3;
    bias[0] = c.b22; bias[1] = c.b21;
    bias[2] = c.b12; bias[3] = c.b11;
    for (int i = 0; i < 4; i++)
      bs[i] = c.men[i] ? s[i] + bias[i] : BIG;
    bnd = (c.px > 64 - c.xres && c.xcur == c.xall)
       || (c.py > 64 - c.yres && c.ycur == c.yall);
    if (bnd) e.part = 3;
    else if (c.men == 0) e.part = 0;
    else begin
      a = (bs[3] < bs[1]) ? 3 : 1;
      b = (bs[2] < bs[0]) ? 2 : 0;
      e.part = (bs[a] < bs[b]) ? a : b;
    end
    e.cst = (s[e.part] > CMAX) ? CMAX : s[e.part];
    acc_m = (pl_m != 0 ? 0 : acc_m) + e.cst;
    if (acc_m > AMAX) acc_m = AMAX;
    pl_m = c.last;
    e.last = c.last;
    e.ctu = acc_m;
    q.push_back(e);
  endtask

  // one clock: record accept, check output, advance
  task automatic cyc(cu_t c);
    exp_t e;
    #1;
    acc_ok = rstn && bus.in_val_i && bus.in_rdy_o;
    if (acc_ok) model(c);
    chk("in_rdy", bus.in_rdy_o,
        !bus.out_val_o || bus.out_rdy_i);
    if (bus.out_val_o === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out", bus.out_val_o, 0);
      end else begin
        e = q[0];
        chk("part", bus.out_part_o, e.part);
        chk("cst", bus.out_cst_o, e.cst);
        chk("last", bus.out_last_o, e.last);
        chk("ctu_cst", bus.out_ctu_cst_o, e.ctu);
        if (bus.out_rdy_i) void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(cu_t c);
    int n;
    drive(c);
    bus.in_val_i = 1'b1;
    n = 0;
    do begin
      cyc(c);
      n++;
    end while (!acc_ok && n < 20);
    if (!acc_ok) chk("send_timeout", 0, 1);
    bus.in_val_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    cu_t d;
    d = mk(0, 0, 0, 0);
    bus.in_val_i = 1'b0;
    bus.out_rdy_i = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      cyc(d);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    cyc(d);
  endtask

  initial begin
    cu_t c;
    cu_t bp[4];
    bit pat[10];
    int idx;
    rstn = 1'b0;
    c = mk(0, 0, 0, 0);
    drive(c);
    bus.in_val_i = 1'b0;
    bus.out_rdy_i = 1'b1;
    acc_m = 0;
    pl_m = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", bus.out_val_o, 0);
    chk("rst_part", bus.out_part_o, 0);
    chk("rst_cst", bus.out_cst_o, 0);
    chk("rst_last", bus.out_last_o, 0);
    chk("rst_ctu", bus.out_ctu_cst_o, 0);
    rstn = 1'b1;

    c = mk(10, 30, 25, 45);
    send(c);
    chk("lat1_val", bus.out_val_o, 0);
    cyc(c);
    chk("lat2_val", bus.out_val_o, 1);
    drain();

    c = mk(25, 50, 50, 100);
    send(c);
    c.b22 = 5;
    send(c);
    drain();

    c = mk(5, 50, 50, 100);
    c.men = 1;
    send(c);
    c = mk(100, 60, 60, 10);
    c.xres = 16; c.xcur = 3; c.xall = 3; c.px = 56;
    send(c);
    c.xres = 0;
    send(c);
    c = mk(CMAX, 50, 50, 100);
    c.xres = 16; c.xcur = 2; c.xall = 2; c.px = 56;
    c.last = 1;
    send(c);
    drain();

    for (int i = 0; i < 4; i++) begin
      c = mk(10, 30, 25, 45);
      c.last = (i == 3) ? 1 : 0;
      send(c);
    end
    c = mk(10, 30, 25, 45);
    send(c);
    drain();

    for (int i = 0; i < 4; i++) begin
      bp[i] = mk(10 + i, 30, 25, 45 + 3 * i);
      bp[i].b11 = 2 * i;
    end
    bp[3].last = 1;
    pat = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    idx = 0;
    for (int t = 0; t < 10; t++) begin
      bus.out_rdy_i = pat[t];
      c = (idx < 4) ? bp[idx] : mk(0, 0, 0, 0);
      drive(c);
      bus.in_val_i = (idx < 4);
      cyc(c);
      if (acc_ok) idx++;
    end
    chk("bp_sent", idx, 4);
    drain();

    c = mk(10, 30, 25, 45);
    drive(c);
    bus.in_val_i = 1'b1;
    cyc(c);
    c = mk(20, 30, 25, 45);
    drive(c);
    cyc(c);
    rstn = 1'b0;
    bus.in_val_i = 1'b0;
    cyc(c);
    q.delete();
    acc_m = 0;
    pl_m = 1;
    chk("mid_rst_val", bus.out_val_o, 0);
    chk("mid_rst_ctu", bus.out_ctu_cst_o, 0);
    rstn = 1'b1;
    repeat (3) cyc(c);
    c = mk(10, 30, 25, 45);
    send(c);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, mis);
    $finish;
  end
endmodule
